// File: rtl/lbus_aes_pkg.sv
// Shared definitions for the SASEBO-GIII local-bus AES register interface:
// address map, CTRL bit positions, block type and the word-lane helper.
package lbus_aes_pkg;

  typedef logic [127:0] block_t;

  localparam logic [15:0] ADDR_CTRL      = 16'h0002;
  localparam logic [15:0] ADDR_MODE      = 16'h000C;
  localparam logic [15:0] ADDR_VER       = 16'h00FC;
  localparam logic [15:0] ADDR_KEY_BASE  = 16'h0100;
  localparam logic [15:0] ADDR_DIN_BASE  = 16'h0140;
  localparam logic [15:0] ADDR_DOUT_BASE = 16'h0180;

  localparam int CTRL_START = 0;
  localparam int CTRL_KEY   = 1;
  localparam int CTRL_SRST  = 2;

  // Word 0 is the most significant lane, so its lsb sits at bit 112 (= (7-idx)*16).
  function automatic logic [6:0] word_lsb(input logic [2:0] idx);
    return {~idx, 4'b0000};
  endfunction

endpackage

// File: rtl/lbus_strobe_sync.sv
// Multi-flop synchroniser for an active-low bus strobe, with single-cycle
// rise and fall pulses taken after the last stage.
module lbus_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/lbus_aes_regif.sv
// Local-bus register file in front of the AES core: key/plaintext staging,
// Krdy/Drdy strobes, busy tracking, ciphertext capture and soft reset.
module lbus_aes_regif
  import lbus_aes_pkg::*;
#(
  parameter logic [15:0] VERSION     = 16'h0001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lbus_a,
  input  logic [15:0] lbus_di,
  output logic [15:0] lbus_do,
  input  logic        lbus_wrn,
  input  logic        lbus_rdn,
  output block_t      blk_kin,
  output block_t      blk_din,
  input  block_t      blk_dout,
  output logic        blk_krdy,
  output logic        blk_drdy,
  input  logic        blk_kvld,
  input  logic        blk_dvld,
  output logic        blk_encdec,
  output logic        blk_en,
  output logic        blk_rstn
);

  logic   wr_rise, rd_fall, unused_wr_fall, unused_rd_rise;
  logic   key_busy, data_busy, srst_q;
  block_t dout_q;
  logic [15:0] rdata;
  logic   key_hit, din_hit, dout_hit, wr_ctrl, cfg_open, key_go, start_go;

  lbus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst(rst), .strobe(lbus_wrn), .rise(wr_rise), .fall(unused_wr_fall)
  );

  lbus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst(rst), .strobe(lbus_rdn), .rise(unused_rd_rise), .fall(rd_fall)
  );

  assign key_hit  = (lbus_a[15:4] == ADDR_KEY_BASE[15:4])  && !lbus_a[0];
  assign din_hit  = (lbus_a[15:4] == ADDR_DIN_BASE[15:4])  && !lbus_a[0];
  assign dout_hit = (lbus_a[15:4] == ADDR_DOUT_BASE[15:4]) && !lbus_a[0];
  assign wr_ctrl  = wr_rise && (lbus_a == ADDR_CTRL);
  assign cfg_open = !key_busy && !data_busy;

  // Both commands are judged on the pre-update busy/srst values; key-load masks start.
  assign key_go   = wr_ctrl && lbus_di[CTRL_KEY] && cfg_open && !srst_q;
  assign start_go = wr_ctrl && lbus_di[CTRL_START] && !lbus_di[CTRL_KEY] && cfg_open && !srst_q;

  always_comb begin
    rdata = '0;
    if (lbus_a == ADDR_CTRL)      rdata = {13'b0, srst_q, key_busy, data_busy};
    else if (lbus_a == ADDR_MODE) rdata = {15'b0, blk_encdec};
    else if (lbus_a == ADDR_VER)  rdata = VERSION;
    else if (key_hit)             rdata = blk_kin[word_lsb(lbus_a[3:1]) +: 16];
    else if (din_hit)             rdata = blk_din[word_lsb(lbus_a[3:1]) +: 16];
    else if (dout_hit)            rdata = dout_q[word_lsb(lbus_a[3:1]) +: 16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lbus_do    <= '0;
      blk_kin    <= '0;
      blk_din    <= '0;
      blk_krdy   <= 1'b0;
      blk_drdy   <= 1'b0;
      blk_encdec <= 1'b0;
      dout_q     <= '0;
      key_busy   <= 1'b0;
      data_busy  <= 1'b0;
      srst_q     <= 1'b0;
    end else begin
      blk_krdy <= key_go;
      blk_drdy <= start_go;
      if (wr_ctrl) srst_q <= lbus_di[CTRL_SRST];

      if (srst_q)        key_busy <= 1'b0;
      else if (key_go)   key_busy <= 1'b1;
      else if (blk_kvld) key_busy <= 1'b0;

      if (srst_q)        data_busy <= 1'b0;
      else if (start_go) data_busy <= 1'b1;
      else if (blk_dvld) data_busy <= 1'b0;

      if (blk_dvld) dout_q <= blk_dout;

      // Core inputs are frozen while an operation is in flight.
      if (wr_rise && cfg_open) begin
        if (lbus_a == ADDR_MODE) blk_encdec <= lbus_di[0];
        if (key_hit) blk_kin[word_lsb(lbus_a[3:1]) +: 16] <= lbus_di;
        if (din_hit) blk_din[word_lsb(lbus_a[3:1]) +: 16] <= lbus_di;
      end

      if (rd_fall) lbus_do <= rdata;
    end
  end

  assign blk_rstn = ~srst_q;
  assign blk_en   = ~srst_q;

endmodule

// File: tb/tb_lbus_aes_regif.sv
// Directed bench for lbus_aes_regif: bus read/write tasks, strobe pulse counters
// and a read scoreboard queue, with the core handshakes driven by hand.
module tb_lbus_aes_regif;
  import lbus_aes_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lbus_a, lbus_di, lbus_do;
  logic        lbus_wrn, lbus_rdn;
  block_t      blk_kin, blk_din, blk_dout;
  logic        blk_krdy, blk_drdy, blk_kvld, blk_dvld, blk_encdec, blk_en, blk_rstn;

  lbus_aes_regif dut (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_do(lbus_do),
    .lbus_wrn(lbus_wrn), .lbus_rdn(lbus_rdn), .blk_kin(blk_kin), .blk_din(blk_din),
    .blk_dout(blk_dout), .blk_krdy(blk_krdy), .blk_drdy(blk_drdy), .blk_kvld(blk_kvld),
    .blk_dvld(blk_dvld), .blk_encdec(blk_encdec), .blk_en(blk_en), .blk_rstn(blk_rstn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int krdy_cnt = 0;
  int drdy_cnt = 0;
  logic [15:0] exp_q[$];

  block_t key_v = 128'h000102030405060708090a0b0c0d0e0f;
  block_t pt_v  = 128'h00112233445566778899aabbccddeeff;
  block_t ct_v  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  block_t din_mod;

  // Counts every clock cycle a strobe is high, so a count of 1 means a one-cycle pulse.
  always begin
    @(posedge clk);
    #2;
    if (blk_krdy) krdy_cnt++;
    if (blk_drdy) drdy_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Commit lands on the posedge between the 4th and 5th negedge after wrn falls.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input bit dvld_at_commit);
    @(negedge clk);
    lbus_a = a; lbus_di = d; lbus_wrn = 1'b0;
    repeat (2) @(negedge clk);
    lbus_wrn = 1'b1;
    repeat (2) @(negedge clk);
    if (dvld_at_commit) blk_dvld = 1'b1;
    @(negedge clk);
    blk_dvld = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    lbus_a = a; lbus_rdn = 1'b0;
    repeat (2) @(negedge clk);
    lbus_rdn = 1'b1;
    repeat (4) @(negedge clk);
    check(tag, {112'b0, lbus_do}, {112'b0, exp_q.pop_front()});
  endtask

  task automatic pulse_kvld();
    @(negedge clk); blk_kvld = 1'b1;
    @(negedge clk); blk_kvld = 1'b0;
  endtask

  task automatic pulse_dvld();
    @(negedge clk); blk_dvld = 1'b1;
    @(negedge clk); blk_dvld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lbus_a = '0; lbus_di = '0; lbus_wrn = 1'b1; lbus_rdn = 1'b1;
    blk_dout = '0; blk_kvld = 1'b0; blk_dvld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_lbus_do", {112'b0, lbus_do}, '0);
    check("rst_kin", blk_kin, '0);
    check("rst_din", blk_din, '0);
    check("rst_strobes", {126'b0, blk_krdy, blk_drdy}, '0);
    check("rst_encdec", {127'b0, blk_encdec}, '0);
    check("rst_en_rstn", {126'b0, blk_en, blk_rstn}, 128'd3);
    bus_read(ADDR_VER, 16'h0001, "read_version");
    bus_read(ADDR_CTRL, 16'h0000, "read_ctrl_idle");

    for (int i = 0; i < 8; i++)
      bus_write(ADDR_KEY_BASE + 16'(2 * i), key_v[127 - 16 * i -: 16], 1'b0);
    check("kin_loaded", blk_kin, key_v);
    bus_write(ADDR_CTRL, 16'h0002, 1'b0);
    check("krdy_one_pulse", 128'(krdy_cnt), 128'd1);
    check("no_drdy_on_keyload", 128'(drdy_cnt), 128'd0);
    bus_read(ADDR_CTRL, 16'h0002, "ctrl_key_busy");
    pulse_kvld();
    bus_read(ADDR_CTRL, 16'h0000, "ctrl_after_kvld");

    for (int i = 0; i < 8; i++)
      bus_write(ADDR_DIN_BASE + 16'(2 * i), pt_v[127 - 16 * i -: 16], 1'b0);
    check("din_loaded", blk_din, pt_v);
    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("drdy_one_pulse", 128'(drdy_cnt), 128'd1);
    bus_read(ADDR_CTRL, 16'h0001, "ctrl_data_busy");
    bus_write(ADDR_DIN_BASE, 16'hFFFF, 1'b0);
    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("din_frozen_busy", blk_din, pt_v);
    check("no_drdy_while_busy", 128'(drdy_cnt), 128'd1);
    blk_dout = ct_v;
    pulse_dvld();
    bus_read(ADDR_CTRL, 16'h0000, "ctrl_after_dvld");
    for (int i = 0; i < 8; i++)
      bus_read(ADDR_DOUT_BASE + 16'(2 * i), ct_v[127 - 16 * i -: 16], "dout_word");

    bus_write(ADDR_DIN_BASE, 16'hFFFF, 1'b0);
    din_mod = {16'hFFFF, pt_v[111:0]};
    check("din_write_after_idle", blk_din, din_mod);
    bus_read(ADDR_DIN_BASE, 16'hFFFF, "din_readback");
    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("drdy_second", 128'(drdy_cnt), 128'd2);
    // Start in the same cycle as dvld: judged against still-busy, so dropped.
    bus_write(ADDR_CTRL, 16'h0001, 1'b1);
    check("start_vs_clear_dropped", 128'(drdy_cnt), 128'd2);
    bus_read(ADDR_CTRL, 16'h0000, "ctrl_cleared_same_cycle");

    bus_write(ADDR_MODE, 16'h0001, 1'b0);
    check("encdec_set", {127'b0, blk_encdec}, 128'd1);
    bus_read(ADDR_MODE, 16'h0001, "mode_readback");
    bus_write(ADDR_MODE, 16'h0000, 1'b0);
    check("encdec_clear", {127'b0, blk_encdec}, '0);
    bus_write(16'h0004, 16'h1234, 1'b0);
    bus_read(16'h0004, 16'h0000, "unmapped_read");

    bus_write(ADDR_CTRL, 16'h0003, 1'b0);
    check("both_krdy", 128'(krdy_cnt), 128'd2);
    check("both_no_drdy", 128'(drdy_cnt), 128'd2);
    pulse_kvld();

    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("drdy_before_srst", 128'(drdy_cnt), 128'd3);
    bus_write(ADDR_CTRL, 16'h0004, 1'b0);
    check("srst_outputs", {126'b0, blk_en, blk_rstn}, '0);
    bus_read(ADDR_CTRL, 16'h0004, "ctrl_srst_busy_cleared");
    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("start_ignored_srst", 128'(drdy_cnt), 128'd3);
    bus_write(ADDR_CTRL, 16'h0000, 1'b0);
    check("srst_released", {126'b0, blk_en, blk_rstn}, 128'd3);
    check("kin_kept_srst", blk_kin, key_v);
    check("din_kept_srst", blk_din, din_mod);
    bus_read(ADDR_DOUT_BASE + 16'h000E, ct_v[15:0], "dout_kept_srst");

    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("drdy_before_rst", 128'(drdy_cnt), 128'd4);
    bus_read(ADDR_VER, 16'h0001, "version_before_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_lbus_do", {112'b0, lbus_do}, '0);
    check("async_rst_kin", blk_kin, '0);
    check("async_rst_din", blk_din, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_read(ADDR_CTRL, 16'h0000, "ctrl_after_rst");
    bus_write(ADDR_CTRL, 16'h0001, 1'b0);
    check("drdy_after_rst", 128'(drdy_cnt), 128'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbus_aes_regif.md
Name: lbus_aes_regif

Overview:
- Local-bus register interface sitting directly upstream of the AES core on the SASEBO-GIII chip.
- Turns host 16-bit bus writes into 128-bit key/plaintext registers and one-cycle Krdy/Drdy strobes.
- Tracks core busy state and captures ciphertext on Dvld for host readback.
- Owns the core's encdec/en/rstn controls.

Parameters:
- VERSION, 16'h0001, value returned at the version address.
- SYNC_STAGES, 2, flops in the lbus_wrn/lbus_rdn synchronisers (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- lbus_a  in  16  byte address; already registered in the clk domain upstream
- lbus_di  in  16  write data; already registered upstream
- lbus_do  out  16  read data
- lbus_wrn  in  1  write strobe, active-low
- lbus_rdn  in  1  read strobe, active-low
- blk_kin  out  128  key to core
- blk_din  out  128  plaintext to core
- blk_dout  in  128  core result
- blk_krdy  out  1  key-load pulse
- blk_drdy  out  1  start pulse
- blk_kvld  in  1  key expansion done
- blk_dvld  in  1  result valid
- blk_encdec  out  1  0=encrypt, 1=decrypt
- blk_en  out  1  core enable
- blk_rstn  out  1  core soft reset, active-low

Behaviour:
- Reset values:
  - lbus_do=0, blk_kin=0, blk_din=0, blk_krdy=0, blk_drdy=0, blk_encdec=0
  - blk_en=1, blk_rstn=1
  - dout capture register=0, key_busy=0, data_busy=0, srst bit=0
- Strobe synchronisation: lbus_wrn and lbus_rdn each pass through SYNC_STAGES flops (reset value 1), then an edge detector.
- Write commit: on the synced rising edge of wrn (end of write). lbus_a and lbus_di are sampled in that cycle. Latency from the raw wrn rise is SYNC_STAGES+1 cycles.
- Read: on the synced falling edge of rdn, lbus_do is loaded in the next cycle and held until the next read.
- Unmapped reads return 16'h0000. Unmapped writes are ignored.
- Address map (byte addresses, word = 16 bits):
  - 0x0002 CTRL W: bit0 start, bit1 key-load, bit2 srst.
  - 0x0002 CTRL R: {13'b0, srst, key_busy, data_busy}.
  - 0x000C MODE R/W: bit0 = blk_encdec.
  - 0x00FC VERSION, read-only.
  - 0x0100-0x010E KEY R/W: 0x0100 maps to kin[127:112]; each +2 steps down 16 bits.
  - 0x0140-0x014E DIN R/W: same layout as KEY.
  - 0x0180-0x018E DOUT, read-only: same layout, reads the capture register.
- Key-load (bit1=1):
  - If key_busy=0, data_busy=0 and srst=0: blk_krdy=1 for exactly one cycle, the cycle after commit, and key_busy is set.
  - Otherwise the bit is ignored.
- Start (bit0=1):
  - If data_busy=0, key_busy=0 and srst=0: blk_drdy=1 for one cycle and data_busy is set.
  - Otherwise ignored, with no pulse.
- Start and key-load written together: key-load wins; start is dropped.
- Busy clearing: key_busy clears on blk_kvld; data_busy clears on blk_dvld.
- Simultaneous set and clear: if a clear event and a new-start evaluation fall in the same cycle, the start is evaluated against the pre-clear busy value (ignored).
- Result capture: when blk_dvld=1, the dout capture register loads blk_dout in the same cycle.
- Data stability: the core samples blk_din one cycle after blk_drdy. Writes to DIN, KEY and MODE are therefore ignored while data_busy or key_busy is set, so registers are stable during operation.
- Soft reset:
  - blk_rstn = ~srst; blk_en = ~srst.
  - While srst=1, key_busy and data_busy are held at 0 and strobes are suppressed.
  - The KEY, DIN and DOUT registers are not cleared by srst.
- Async rst mid-operation: all state returns to reset values immediately. Any pulse in flight is truncated.

Decomposition:
- Shared package lbus_aes_pkg holds:
  - address constants ADDR_CTRL, ADDR_MODE, ADDR_VER, ADDR_KEY_BASE, ADDR_DIN_BASE, ADDR_DOUT_BASE
  - CTRL bit indices
  - a 128-bit block type
- One sub-module, lbus_strobe_sync: a SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated once each for wrn and rdn.

Test Plan:
- Reset release -> all outputs at reset values; reading 0x00FC returns 16'h0001; reading 0x0002 returns 0.
- Write KEY 000102030405060708090a0b0c0d0e0f, write CTRL=2 -> exactly one blk_krdy pulse; CTRL reads 2 until kvld, then 0.
- Write DIN 00112233445566778899aabbccddeeff, write CTRL=1; core model drives dvld with dout 69c4e0d86a7b0430d8cdb78070b4c55a -> one blk_drdy pulse; DOUT words read back 69c4..c55a; CTRL reads 0.
- While data_busy: write DIN word 0x0140=FFFF and CTRL=1 -> blk_din unchanged, no second drdy; after dvld, the same writes take effect.
- Write CTRL=4 -> blk_rstn=0, blk_en=0, and CTRL=1 is ignored; write CTRL=0 -> blk_rstn=1, and KEY/DIN retain their values.
- Assert rst during busy -> busy flags clear, blk_kin=0, lbus_do=0 immediately; after release, CTRL=1 produces a pulse.
